// File: rtl/anc_mac_pkg.sv
// -----------------------------------------------------------------------------
// anc_mac_pkg
// Shared types and constants for the FIR MAC scheduler of the ANC datapath.
//   state_e  : scheduler FSM states (IDLE, FETCH, MAC, DRAIN, OUTPUT)
//   DW       : sample / coefficient width (Q15)
//   PW       : full product width of the external 16x16 multiplier
//   FRAC     : fractional bits dropped when returning to Q15
//   Q15_MAX / Q15_MIN : clamp limits of a Q15 result
// -----------------------------------------------------------------------------
package anc_mac_pkg;

    localparam int DW   = 16;
    localparam int PW   = 32;
    localparam int FRAC = 15;

    localparam logic signed [DW-1:0] Q15_MAX = 16'sh7FFF;
    localparam logic signed [DW-1:0] Q15_MIN = 16'sh8000;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        FETCH  = 3'd1,
        MAC    = 3'd2,
        DRAIN  = 3'd3,
        OUTPUT = 3'd4
    } state_e;

endpackage

// File: rtl/fir_delay_line.sv
// -----------------------------------------------------------------------------
// fir_delay_line
// NTAPS x DW sample shift register. x[0] holds the newest sample; a shift
// moves every sample one tap older and drops the oldest one.
//   clk_i      : clock, rising edge
//   rst_ni     : asynchronous active-low reset, clears all taps
//   shift_en_i : shift din_i into x[0]
//   clr_i      : synchronous clear of all taps (has priority over shift)
//   din_i      : new sample
//   rd_idx_i   : tap index for the combinational read port
//   rd_data_o  : x[rd_idx_i]
// -----------------------------------------------------------------------------
module fir_delay_line
    import anc_mac_pkg::*;
#(
    parameter int  NTAPS = 8,
    localparam int CAW   = $clog2(NTAPS)
) (
    input  logic           clk_i,
    input  logic           rst_ni,
    input  logic           shift_en_i,
    input  logic           clr_i,
    input  logic [DW-1:0]  din_i,
    input  logic [CAW-1:0] rd_idx_i,
    output logic [DW-1:0]  rd_data_o
);

    logic [DW-1:0] taps_q [NTAPS];

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < NTAPS; i++) taps_q[i] <= '0;
        end else if (clr_i) begin
            for (int i = 0; i < NTAPS; i++) taps_q[i] <= '0;
        end else if (shift_en_i) begin
            taps_q[0] <= din_i;
            for (int i = 1; i < NTAPS; i++) taps_q[i] <= taps_q[i-1];
        end
    end

    // NTAPS is a power of two, so every rd_idx_i value is a valid tap.
    assign rd_data_o = taps_q[rd_idx_i];

endmodule

// File: rtl/fir_mac_scheduler.sv
// -----------------------------------------------------------------------------
// fir_mac_scheduler
// Time-multiplexes one external 16x16 signed multiplier over NTAPS FIR taps
// for each accepted Q15 sample and returns a Q15 result.
//
// Optional feature macro: FIR_MAC_SATURATE_EN
//   defined   : result clamps to [-32768, 32767], sat_flag is sticky on clamp
//   undefined : result is the low 16 bits of (acc >>> 15), sat_flag = 0
//
// Ports:
//   clk, rst (async, active-low)
//   in_valid / in_data / in_ready    : sample input, in_ready only in IDLE
//   coef_addr / coef_data            : coefficient RAM, 1-cycle sync read
//   mul_a / mul_b / mul_p            : external multiplier, MULT_LAT cycles
//   out_valid / out_data / out_ready : result output, held while stalled
//   busy        : high in every state except IDLE
//   sat_flag    : sticky saturation indicator
//   dbg_state_o : current FSM state
//
// Handshake: a transfer happens on a rising edge where valid and ready are
// both high; valid and data are held until that edge.
//
// Schedule for a sample accepted at edge T:
//   FETCH  : 1 cycle, coef_addr = 0
//   MAC    : NTAPS cycles, tap k: mul_a = x[k], mul_b = coef k, addr = k+1
//   DRAIN  : until the last product has been accumulated (absent if
//            MULT_LAT = 0)
//   OUTPUT : out_valid from cycle T+2+NTAPS+MULT_LAT until accepted
// -----------------------------------------------------------------------------
module fir_mac_scheduler
    import anc_mac_pkg::*;
#(
    parameter int  NTAPS    = 8,
    parameter int  MULT_LAT = 1,
    parameter int  ACCW     = 40,
    localparam int CAW      = $clog2(NTAPS)
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           in_valid,
    input  logic [DW-1:0]  in_data,
    output logic           in_ready,
    output logic [CAW-1:0] coef_addr,
    input  logic [DW-1:0]  coef_data,
    output logic [DW-1:0]  mul_a,
    output logic [DW-1:0]  mul_b,
    input  logic [PW-1:0]  mul_p,
    output logic           out_valid,
    output logic [DW-1:0]  out_data,
    input  logic           out_ready,
    output logic           busy,
    output logic           sat_flag,
    output state_e         dbg_state_o
);

    state_e                  state_q, state_d;
    logic [CAW-1:0]          cnt_q;
    logic [CAW-1:0]          coef_addr_q;
    logic signed [ACCW-1:0]  acc_q, acc_d;
    logic                    in_ready_q, busy_q, out_valid_q;
    logic [DW-1:0]           out_data_q;
    logic [DW-1:0]           res_d;
    logic [DW-1:0]           tap_rd;
    logic signed [ACCW-1:0]  prod_ext;
    logic                    accept;
    logic                    tag_emerge;
    logic                    tags_pending;
    logic                    load_out;

    assign accept   = in_valid && in_ready_q;
    assign prod_ext = ACCW'($signed(mul_p));

    fir_delay_line #(
        .NTAPS (NTAPS)
    ) u_delay_line (
        .clk_i      (clk),
        .rst_ni     (rst),
        .shift_en_i (accept),
        .clr_i      (1'b0),
        .din_i      (in_data),
        .rd_idx_i   (cnt_q),
        .rd_data_o  (tap_rd)
    );

    // Each MAC cycle launches a tag alongside its operands; the tag comes out
    // of the pipe in the same cycle the matching product is on mul_p.
    generate
        if (MULT_LAT == 0) begin : g_comb_mult
            assign tag_emerge   = (state_q == MAC);
            assign tags_pending = 1'b0;
        end else begin : g_tag_pipe
            logic [MULT_LAT-1:0] tag_q;

            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    tag_q <= '0;
                end else begin
                    tag_q[0] <= (state_q == MAC);
                    for (int i = 1; i < MULT_LAT; i++) tag_q[i] <= tag_q[i-1];
                end
            end

            assign tag_emerge = tag_q[MULT_LAT-1];

            // Tags still in flight behind the one retiring this cycle.
            always_comb begin
                tags_pending = 1'b0;
                for (int i = 0; i < MULT_LAT - 1; i++) begin
                    tags_pending = tags_pending | tag_q[i];
                end
            end
        end
    endgenerate

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (accept) state_d = FETCH;
            FETCH:   state_d = MAC;
            MAC:     if (cnt_q == CAW'(NTAPS - 1)) state_d = (MULT_LAT == 0) ? OUTPUT : DRAIN;
            DRAIN:   if (!tags_pending) state_d = OUTPUT;
            OUTPUT:  if (out_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        acc_d = acc_q;
        if (accept) begin
            acc_d = '0;
        end else if (tag_emerge) begin
            acc_d = acc_q + prod_ext;
        end
    end

    // acc_d already holds the final sum on the edge that enters OUTPUT.
    assign load_out = (state_d == OUTPUT) && (state_q != OUTPUT);

`ifdef FIR_MAC_SATURATE_EN
    logic signed [ACCW-1:0] acc_sh;
    logic                   clamp_d;
    logic                   sat_q;

    always_comb begin
        acc_sh  = acc_d >>> FRAC;
        clamp_d = 1'b0;
        res_d   = acc_sh[DW-1:0];
        if (acc_sh > ACCW'(Q15_MAX)) begin
            res_d   = Q15_MAX;
            clamp_d = 1'b1;
        end else if (acc_sh < ACCW'(Q15_MIN)) begin
            res_d   = Q15_MIN;
            clamp_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sat_q <= 1'b0;
        end else if (load_out && clamp_d) begin
            sat_q <= 1'b1;
        end
    end

    assign sat_flag = sat_q;
`else
    // Wrap-around: bits [FRAC +: DW] are the low 16 bits of acc >>> FRAC.
    always_comb res_d = acc_d[FRAC +: DW];

    assign sat_flag = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            coef_addr_q <= '0;
            acc_q       <= '0;
            in_ready_q  <= 1'b0;
            busy_q      <= 1'b0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
        end else begin
            state_q     <= state_d;
            acc_q       <= acc_d;
            cnt_q       <= (state_q == MAC) ? cnt_q + 1'b1 : '0;
            // Address runs one tap ahead of the MAC index to hide the RAM
            // read latency; it wraps to 0 on the last MAC cycle.
            coef_addr_q <= (state_d == MAC) ? coef_addr_q + 1'b1 : '0;
            in_ready_q  <= (state_d == IDLE);
            busy_q      <= (state_d != IDLE);
            out_valid_q <= (state_d == OUTPUT);
            if (load_out) out_data_q <= res_d;
        end
    end

    assign mul_a       = (state_q == MAC) ? tap_rd : '0;
    assign mul_b       = (state_q == MAC) ? coef_data : '0;
    assign coef_addr   = coef_addr_q;
    assign in_ready    = in_ready_q;
    assign busy        = busy_q;
    assign out_valid   = out_valid_q;
    assign out_data    = out_data_q;
    assign dbg_state_o = state_q;

endmodule

// File: tb/tb_fir_mac_scheduler.sv
// -----------------------------------------------------------------------------
// tb_fir_mac_scheduler
// Bench for fir_mac_scheduler: a MULT_LAT=1 instance drives most scenarios, a
// MULT_LAT=3 instance covers the latency variant. Coefficient RAM and
// multipliers are modelled here; expected results come from a direct
// convolution model and are queued when each sample is driven.
// -----------------------------------------------------------------------------
module tb_fir_mac_scheduler;
    import anc_mac_pkg::*;

    localparam int NTAPS = 8;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    // ---------------- DUT (MULT_LAT = 1) ----------------
    logic        in_valid, in_ready, out_valid, out_ready, busy, sat_flag;
    logic [15:0] in_data, coef_data, mul_a, mul_b, out_data;
    logic [2:0]  coef_addr;
    logic [31:0] mul_p;
    state_e      dbg_state;

    // ---------------- DUT (MULT_LAT = 3) ----------------
    logic        in_valid3, in_ready3, out_valid3, out_ready3, busy3, sat_flag3;
    logic [15:0] in_data3, coef_data3, mul_a3, mul_b3, out_data3;
    logic [2:0]  coef_addr3;
    logic [31:0] mul_p3, p3_s1, p3_s2;
    state_e      dbg_state3;

    fir_mac_scheduler #(.NTAPS(NTAPS), .MULT_LAT(1), .ACCW(40)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
        .coef_addr(coef_addr), .coef_data(coef_data),
        .mul_a(mul_a), .mul_b(mul_b), .mul_p(mul_p),
        .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready),
        .busy(busy), .sat_flag(sat_flag), .dbg_state_o(dbg_state)
    );

    fir_mac_scheduler #(.NTAPS(NTAPS), .MULT_LAT(3), .ACCW(40)) dut3 (
        .clk(clk), .rst(rst),
        .in_valid(in_valid3), .in_data(in_data3), .in_ready(in_ready3),
        .coef_addr(coef_addr3), .coef_data(coef_data3),
        .mul_a(mul_a3), .mul_b(mul_b3), .mul_p(mul_p3),
        .out_valid(out_valid3), .out_data(out_data3), .out_ready(out_ready3),
        .busy(busy3), .sat_flag(sat_flag3), .dbg_state_o(dbg_state3)
    );

    // ---------------- coefficient RAM and multiplier models ----------------
    logic signed [15:0] coef_mem [NTAPS];

    always @(posedge clk) begin
        coef_data  <= coef_mem[coef_addr];
        coef_data3 <= coef_mem[coef_addr3];
        mul_p      <= 32'(signed'(mul_a)) * 32'(signed'(mul_b));
        p3_s1      <= 32'(signed'(mul_a3)) * 32'(signed'(mul_b3));
        p3_s2      <= p3_s1;
        mul_p3     <= p3_s2;
    end

    // ---------------- scoreboard ----------------
    logic [15:0]        exp_q[$];
    logic signed [15:0] x_m [NTAPS];
    logic [15:0]        mon_exp;
    int                 vectors    = 0;
    int                 miscompares = 0;
    time                last_accept;

    function automatic logic [15:0] model_out();
        logic signed [63:0] s;
        logic signed [63:0] sh;
        s = 64'sd0;
        for (int k = 0; k < NTAPS; k++) s = s + 64'(x_m[k]) * 64'(coef_mem[k]);
        sh = s >>> 15;
`ifdef FIR_MAC_SATURATE_EN
        if (sh > 64'sd32767)  return 16'h7FFF;
        if (sh < -64'sd32768) return 16'h8000;
`endif
        return sh[15:0];
    endfunction

    always @(negedge clk) begin
        if (rst === 1'b1 && out_valid === 1'b1 && out_ready === 1'b1) begin
            vectors++;
            if (exp_q.size() == 0) begin
                miscompares++;
                $display("FAIL out_data unexpected result got=%h exp=none", out_data);
            end else begin
                mon_exp = exp_q.pop_front();
                if (out_data !== mon_exp) begin
                    miscompares++;
                    $display("FAIL out_data got=%h exp=%h", out_data, mon_exp);
                end
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_model();
        for (int k = 0; k < NTAPS; k++) x_m[k] = '0;
        exp_q.delete();
    endtask

    task automatic set_coefs_identity();
        for (int k = 0; k < NTAPS; k++) coef_mem[k] = (k == 0) ? 16'sh7FFF : 16'sh0000;
    endtask

    task automatic send_sample(input logic [15:0] d);
        int n = 0;
        while (in_ready !== 1'b1 && n < 200) begin
            tick();
            n++;
        end
        if (in_ready !== 1'b1) begin
            vectors++;
            miscompares++;
            $display("FAIL in_ready_timeout got=%b exp=1", in_ready);
            return;
        end
        in_valid = 1'b1;
        in_data  = d;
        for (int k = NTAPS - 1; k > 0; k--) x_m[k] = x_m[k-1];
        x_m[0] = d;
        exp_q.push_back(model_out());
        tick();
        last_accept = $time;
        in_valid = 1'b0;
    endtask

    task automatic wait_drain();
        int n = 0;
        while (exp_q.size() != 0 && n < 300) begin
            tick();
            n++;
        end
        vectors++;
        if (exp_q.size() != 0) begin
            miscompares++;
            $display("FAIL drain_timeout got=%0d pending exp=0", exp_q.size());
            exp_q.delete();
        end
        tick();
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        rst = 1'b0;
        in_valid = 1'b0; in_data = '0; out_ready = 1'b1;
        in_valid3 = 1'b0; in_data3 = '0; out_ready3 = 1'b1;
        clear_model();
        for (int k = 0; k < NTAPS; k++) coef_mem[k] = '0;
        repeat (3) @(negedge clk);
        vectors++;
        if ({out_valid, busy, sat_flag} !== 3'b000) begin
            miscompares++;
            $display("FAIL reset_flags got=%b exp=000", {out_valid, busy, sat_flag});
        end
        vectors++;
        if (out_data !== 16'h0000 || mul_a !== 16'h0000 || mul_b !== 16'h0000) begin
            miscompares++;
            $display("FAIL reset_data got=%h/%h/%h exp=0/0/0", out_data, mul_a, mul_b);
        end
        vectors++;
        if (coef_addr !== 3'd0 || dbg_state !== IDLE) begin
            miscompares++;
            $display("FAIL reset_addr_state got=%0d/%0d exp=0/0", coef_addr, dbg_state);
        end
        rst = 1'b1;
        tick();
        vectors++;
        if (in_ready !== 1'b1 || in_ready3 !== 1'b1) begin
            miscompares++;
            $display("FAIL reset_in_ready got=%b%b exp=11", in_ready, in_ready3);
        end
    endtask

    task automatic test_impulse();
        time prev;
        for (int k = 0; k < NTAPS; k++) coef_mem[k] = 16'(1000 * (k + 1));
        out_ready = 1'b1;
        send_sample(16'h7FFF);
        for (int i = 1; i < NTAPS; i++) begin
            prev = last_accept;
            send_sample(16'h0000);
            vectors++;
            if (last_accept - prev != (NTAPS + 1 + 3) * 10) begin
                miscompares++;
                $display("FAIL throughput got=%0t exp=%0d", last_accept - prev, (NTAPS + 4) * 10);
            end
        end
        wait_drain();
    endtask

    task automatic test_identity();
        int lat = -1;
        set_coefs_identity();
        out_ready = 1'b1;
        send_sample(16'h1000);
        for (int n = 1; n <= 40; n++) begin
            @(negedge clk);
            if (out_valid === 1'b1) begin
                lat = n;
                break;
            end
        end
        vectors++;
        if (lat != 2 + NTAPS + 1) begin
            miscompares++;
            $display("FAIL identity_latency got=%0d exp=%0d", lat, 2 + NTAPS + 1);
        end
        vectors++;
        if (out_data !== 16'h0FFF) begin
            miscompares++;
            $display("FAIL identity_value got=%h exp=0fff", out_data);
        end
        wait_drain();
    endtask

    task automatic test_backpressure();
        int n = 0;
        for (int k = 0; k < NTAPS; k++) coef_mem[k] = 16'($urandom_range(0, 4000));
        out_ready = 1'b0;
        send_sample(16'($urandom_range(0, 16'h3FFF)));
        while (out_valid !== 1'b1 && n < 60) begin
            @(negedge clk);
            n++;
        end
        vectors++;
        if (out_valid !== 1'b1) begin
            miscompares++;
            $display("FAIL bp_out_valid_timeout got=%b exp=1", out_valid);
        end
        for (int c = 0; c < 5; c++) begin
            tick();
            in_valid = 1'b1;
            in_data  = 16'($urandom_range(1, 16'hFFFF));
            @(negedge clk);
            vectors++;
            if (exp_q.size() == 0 || out_data !== exp_q[0] || out_valid !== 1'b1 || in_ready !== 1'b0) begin
                miscompares++;
                $display("FAIL bp_hold got=%h v=%b r=%b exp=%h v=1 r=0",
                         out_data, out_valid, in_ready, (exp_q.size() != 0) ? exp_q[0] : 16'h0);
            end
        end
        tick();
        out_ready = 1'b1;
        tick();
        in_valid = 1'b0;
        send_sample(16'($urandom_range(0, 16'h3FFF)));
        wait_drain();
    endtask

    task automatic test_overflow();
        for (int k = 0; k < NTAPS; k++) coef_mem[k] = 16'sh7FFF;
        out_ready = 1'b1;
        for (int i = 0; i < NTAPS; i++) send_sample(16'h7FFF);
        wait_drain();
        vectors++;
`ifdef FIR_MAC_SATURATE_EN
        if (sat_flag !== 1'b1) begin
            miscompares++;
            $display("FAIL overflow_sat_flag got=%b exp=1", sat_flag);
        end
`else
        if (sat_flag !== 1'b0) begin
            miscompares++;
            $display("FAIL overflow_sat_flag got=%b exp=0", sat_flag);
        end
`endif
    endtask

    task automatic test_reset_mid_mac();
        int seen = 0;
        out_ready = 1'b1;
        in_valid = 1'b1;
        in_data  = 16'h4321;
        tick();
        in_valid = 1'b0;
        repeat (5) tick();
        vectors++;
        if (dbg_state !== MAC || busy !== 1'b1) begin
            miscompares++;
            $display("FAIL mid_mac_state got=%0d/%b exp=%0d/1", dbg_state, busy, MAC);
        end
        rst = 1'b0;
        clear_model();
        #1;
        vectors++;
        if (busy !== 1'b0 || out_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL mid_mac_reset got=%b%b exp=00", busy, out_valid);
        end
        repeat (2) @(negedge clk);
        rst = 1'b1;
        for (int c = 0; c < 15; c++) begin
            @(negedge clk);
            if (out_valid !== 1'b0) seen++;
        end
        vectors++;
        if (seen != 0) begin
            miscompares++;
            $display("FAIL mid_mac_no_output got=%0d exp=0", seen);
        end
        vectors++;
        if (in_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL mid_mac_in_ready got=%b exp=1", in_ready);
        end
        // All taps weighted: any stale delay-line content shows in the result.
        for (int k = 0; k < NTAPS; k++) coef_mem[k] = 16'sh7FFF;
        send_sample(16'h1000);
        wait_drain();
        test_identity();
    endtask

    task automatic test_latency3();
        int lat = -1;
        set_coefs_identity();
        out_ready3 = 1'b1;
        in_valid3  = 1'b1;
        in_data3   = 16'h1000;
        tick();
        in_valid3 = 1'b0;
        for (int n = 1; n <= 40; n++) begin
            @(negedge clk);
            if (out_valid3 === 1'b1) begin
                lat = n;
                break;
            end
        end
        vectors++;
        if (lat != 2 + NTAPS + 3) begin
            miscompares++;
            $display("FAIL lat3_latency got=%0d exp=%0d", lat, 2 + NTAPS + 3);
        end
        vectors++;
        if (out_data3 !== 16'h0FFF) begin
            miscompares++;
            $display("FAIL lat3_value got=%h exp=0fff", out_data3);
        end
        repeat (2) tick();
        vectors++;
        if (out_valid3 !== 1'b0 || in_ready3 !== 1'b1) begin
            miscompares++;
            $display("FAIL lat3_return got=%b%b exp=01", out_valid3, in_ready3);
        end
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        test_reset();
        test_impulse();
        test_identity();
        test_backpressure();
        test_overflow();
        test_reset_mid_mac();
        test_latency3();
        vectors++;
        if (exp_q.size() != 0) begin
            miscompares++;
            $display("FAIL leftover_expected got=%0d exp=0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired got=running exp=finished");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/fir_mac_scheduler.md
Name: fir_mac_scheduler

Overview:
- Sequences one shared external 16x16 signed multiplier across NTAPS FIR taps for each accepted input sample.
- Steps the coefficient memory address, feeds multiplier operands, collects products after MULT_LAT cycles, accumulates them, and returns a Q15-scaled 16-bit filter output.
- Sits between the ADC sample stream and the anti-noise output path of the ANC datapath.

Parameters:
- NTAPS, 8, number of filter taps (power of 2, 2..64).
- MULT_LAT, 1, cycles from operand presentation to product on mul_p (0..3; 0 = combinational multiplier).
- ACCW, 40, accumulator width in bits.
- Derived localparam CAW = clog2(NTAPS), the coefficient address width.

Ports:
- clk  in  1  single system clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- in_valid  in  1  input sample valid.
- in_data  in  16  signed Q15 input sample.
- in_ready  out  1  block can accept a sample.
- coef_addr  out  CAW  coefficient memory address; synchronous read, data valid 1 cycle later.
- coef_data  in  16  signed Q15 coefficient.
- mul_a  out  16  multiplier operand A (delay-line tap).
- mul_b  out  16  multiplier operand B (coefficient).
- mul_p  in  32  signed product from the external multiplier.
- out_valid  out  1  result valid.
- out_data  out  16  signed Q15 result.
- out_ready  in  1  downstream accepts the result.
- busy  out  1  high in every state except IDLE.
- sat_flag  out  1  sticky saturation indicator.

Behaviour:
- Reset (rst=0):
  - State goes to IDLE; delay line and accumulator clear.
  - in_ready=1 once rst=1; out_valid=0, out_data=0, busy=0, sat_flag=0, coef_addr=0, mul_a=0, mul_b=0.
  - Reset mid-operation aborts the computation; the partial sum is discarded and nothing is emitted.
- State machine:
  - IDLE -> FETCH -> MAC -> DRAIN -> OUTPUT -> IDLE.
  - DRAIN is skipped when MULT_LAT=0.
- IDLE:
  - in_ready=1.
  - On in_valid&in_ready at edge T: shift in_data into x[0] (x[k] <= x[k-1], oldest sample dropped) and clear acc.
- FETCH (cycle T+1): coef_addr=0.
- MAC (cycles T+2 .. T+1+NTAPS):
  - In cycle T+2+k: mul_a=x[k], mul_b=coef_data (coefficient k), coef_addr=k+1 (wraps to 0, result ignored).
  - A MULT_LAT-deep valid-tag pipeline marks each product.
  - acc += sign-extended mul_p on the edge where the tag emerges.
- DRAIN: wait until all NTAPS tags have retired.
- OUTPUT:
  - out_valid=1 from cycle T+2+NTAPS+MULT_LAT (T+11 at defaults).
  - out_data = (acc >>> 15) reduced to 16 bits.
  - out_data is held stable while out_ready=0.
  - On out_valid&out_ready: go to IDLE and drop out_valid next cycle.
- Operand gating: mul_a and mul_b are 0 outside MAC.
- Handshake: in_ready=0 in every state except IDLE; no new sample is accepted while a result is pending.
- Throughput: one sample per NTAPS+MULT_LAT+3 cycles with out_ready tied high.
- Arithmetic: all operations signed; each product is the full 32-bit value, sign-extended to ACCW; no intermediate rounding.

Optional Feature:
- Macro FIR_MAC_SATURATE_EN.
- Defined:
  - out_data clamps (acc >>> 15) to [-32768, 32767].
  - sat_flag sets to 1 on any clamp and stays set until reset.
- Undefined:
  - out_data takes the low 16 bits of (acc >>> 15), i.e. wrap-around.
  - sat_flag is tied to 0.

Decomposition:
- Package anc_mac_pkg holds:
  - State enum (IDLE, FETCH, MAC, DRAIN, OUTPUT).
  - DW=16, PW=32, FRAC=15.
  - Q15_MAX=16'sh7FFF, Q15_MIN=16'sh8000.
- One sub-module, fir_delay_line: NTAPS x 16 shift register with shift-enable, clear, and indexed combinational read.

Test Plan:
- Identity: coef[0]=0x7FFF, other coefs 0, in_data=0x1000 -> out_data=0x0FFF, out_valid at T+11.
- Impulse: coefs 1000,2000..8000, input 0x7FFF then seven 0x0000 -> outputs 999,1999..7999 in order.
- Backpressure: out_ready=0 for 5 cycles after out_valid -> out_data stable, in_ready=0, concurrent in_valid ignored, and the delay line is not shifted.
- Overflow: all coefs 0x7FFF, eight inputs of 0x7FFF.
  - Eighth output without the macro: 0xFFF0.
  - With FIR_MAC_SATURATE_EN: 0x7FFF and sat_flag=1.
- Reset mid-MAC: drive rst=0 during MAC cycle 4 -> out_valid stays 0 and busy=0.
  - After release, in_ready=1 and the delay line reads all zero.
  - Then rerun the identity case -> 0x0FFF.
- Latency variant, MULT_LAT=3 with the identity case -> out_valid at T+13, same value 0x0FFF.
